// File: rtl/rf_plus_alu_if.sv
// rtl/rf_plus_alu_if.sv - controller-to-datapath bundle for the RF + ALU slice
interface rf_plus_alu_if;
    logic [10:0] Ins;
    logic [15:0] WBData;
    logic [15:0] MEMData;
    logic        WBRF;
    logic        WBresource;
    logic        RBresource;
    logic        OprandB;
    logic        LI;
    logic        ALUop;
    logic        Flag;
    logic        PSW_C;
    logic [15:0] Rm;
    logic [15:0] Rd;
    logic [15:0] OutR;
    logic [15:0] LI_EXE;
    logic [15:0] Sum;
    logic        N;
    logic        Z;
    logic        C;

    modport master (
        output Ins, WBData, MEMData, WBRF, WBresource, RBresource,
               OprandB, LI, ALUop, Flag, PSW_C,
        input  Rm, Rd, OutR, LI_EXE, Sum, N, Z, C
    );

    modport slave (
        input  Ins, WBData, MEMData, WBRF, WBresource, RBresource,
               OprandB, LI, ALUop, Flag, PSW_C,
        output Rm, Rd, OutR, LI_EXE, Sum, N, Z, C
    );
endinterface

// File: rtl/rf_plus_alu.sv
// rtl/rf_plus_alu.sv - 8x16 register file, ID/EXE operand latch and add/sub ALU
// Optional write-through bypass on the read ports: define RF_BYPASS_EN.
module rf_plus_alu #(
    parameter int DW   = 16,
    parameter int NREG = 8
) (
    input  logic         clk,
    input  logic         Reset,
    rf_plus_alu_if.slave bus
);
    logic [DW-1:0] rf_q [NREG];
    logic [DW-1:0] rf_d [NREG];
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [DW-1:0] d_q, d_d;
    logic [7:0]    i_q, i_d;

    logic [2:0]    rd_addr, rm_addr, rn_addr, rb_addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rm_val, rd_val, rb_val;

    assign rd_addr = bus.Ins[10:8];
    assign rm_addr = bus.Ins[7:5];
    assign rn_addr = bus.Ins[4:2];
    assign rb_addr = bus.RBresource ? rd_addr : rn_addr;
    assign wdata   = bus.WBresource ? bus.MEMData : bus.WBData;

    // The write port always targets Ins[10:8], so bypass compares against rd_addr.
    always_comb begin
        rm_val = rf_q[rm_addr];
        rd_val = rf_q[rd_addr];
        rb_val = rf_q[rb_addr];
`ifdef RF_BYPASS_EN
        if (bus.WBRF) begin
            rd_val = wdata;
            if (rm_addr == rd_addr) rm_val = wdata;
            if (rb_addr == rd_addr) rb_val = wdata;
        end
`else
`endif
    end

    // WBRF gates the whole write so unknown address/data cannot leak in when it is low.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            rf_d[i] = (bus.WBRF && (rd_addr == 3'(i))) ? wdata : rf_q[i];
        end
        a_d = rm_val;
        b_d = rb_val;
        d_d = rd_val;
        i_d = bus.Ins[7:0];
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
            a_q <= '0;
            b_q <= '0;
            d_q <= '0;
            i_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= rf_d[i];
            a_q <= a_d;
            b_q <= b_d;
            d_q <= d_d;
            i_q <= i_d;
        end
    end

    logic [DW-1:0] op_b, b_x;
    logic          cin;
    logic [DW:0]   sum_full;

    // Subtract is A + ~B + 1; ADC/SBC replace the +1/+0 with the stored carry.
    always_comb begin
        op_b     = bus.OprandB ? {{(DW-5){1'b0}}, i_q[4:0]} : b_q;
        b_x      = bus.ALUop ? ~op_b : op_b;
        cin      = bus.Flag ? bus.PSW_C : bus.ALUop;
        sum_full = {1'b0, a_q} + {1'b0, b_x} + {{DW{1'b0}}, cin};
    end

    assign bus.Rm     = rm_val;
    assign bus.Rd     = rd_val;
    assign bus.OutR   = d_q;
    assign bus.Sum    = sum_full[DW-1:0];
    assign bus.C      = sum_full[DW];
    assign bus.Z      = (sum_full[DW-1:0] == '0);
    assign bus.N      = sum_full[DW-1];
    assign bus.LI_EXE = bus.LI ? {i_q, b_q[7:0]} : {8'h00, i_q};
endmodule

// File: tb/tb_rf_plus_alu.sv
// tb/tb_rf_plus_alu.sv - directed self-checking bench for rf_plus_alu
module tb_rf_plus_alu;
    logic clk;
    logic Reset;
    int   checks;
    int   failures;

    rf_plus_alu_if bus ();
    rf_plus_alu dut (.clk(clk), .Reset(Reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] exp_sum [8] = '{16'h0002, 16'h0004, 16'h0000, 16'hFFFF,
                                 16'h000A, 16'h000D, 16'h0000, 16'h0000};
    logic        exp_c   [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        exp_z   [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        exp_n   [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_controls;
        bus.Ins        = '0;
        bus.WBData     = '0;
        bus.MEMData    = '0;
        bus.WBRF       = 1'b0;
        bus.WBresource = 1'b0;
        bus.RBresource = 1'b0;
        bus.OprandB    = 1'b0;
        bus.LI         = 1'b0;
        bus.ALUop      = 1'b0;
        bus.Flag       = 1'b0;
        bus.PSW_C      = 1'b0;
    endtask

    task automatic test_reset;
        idle_controls();
        Reset = 1'b0;
        repeat (3) tick();
        checks++;
        if ({bus.Rm, bus.Rd, bus.OutR, bus.Sum, bus.LI_EXE} !== 80'h0) begin
            failures++;
            $display("FAIL reset_data got Rm=%h Rd=%h OutR=%h Sum=%h LI=%h want 0",
                     bus.Rm, bus.Rd, bus.OutR, bus.Sum, bus.LI_EXE);
        end
        checks++;
        if ({bus.N, bus.Z, bus.C} !== 3'b010) begin
            failures++;
            $display("FAIL reset_flags got NZC=%b want 010", {bus.N, bus.Z, bus.C});
        end
        @(negedge clk);
        Reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.Ins = {3'(i), 3'(i), 5'd0};
            #1;
            checks++;
            if (bus.Rm !== 16'h0 || bus.Rd !== 16'h0) begin
                failures++;
                $display("FAIL reset_rf[%0d] got Rm=%h Rd=%h want 0", i, bus.Rm, bus.Rd);
            end
        end
    endtask

    task automatic test_rf_fill;
        for (int i = 0; i < 8; i++) begin
            bus.Ins        = {3'(i), 3'(i), 3'(i), 2'b00};
            bus.WBData     = 16'(i + 1);
            bus.WBRF       = 1'b1;
            bus.WBresource = 1'b0;
            tick();
            bus.WBRF = 1'b0;
            #1;
            checks++;
            if (bus.Rm !== 16'(i + 1) || bus.Rd !== 16'(i + 1)) begin
                failures++;
                $display("FAIL rf_fill[%0d] got Rm=%h Rd=%h want %h", i, bus.Rm, bus.Rd, 16'(i + 1));
            end
        end
    endtask

    task automatic test_x_no_write;
        bus.WBRF       = 1'b0;
        bus.Ins        = 'x;
        bus.WBresource = 1'bx;
        bus.WBData     = 'x;
        bus.MEMData    = 'x;
        tick();
        idle_controls();
        for (int i = 0; i < 8; i++) begin
            bus.Ins = {3'(i), 8'd0};
            #1;
            checks++;
            if (bus.Rd !== 16'(i + 1)) begin
                failures++;
                $display("FAIL x_no_write[%0d] got %h want %h", i, bus.Rd, 16'(i + 1));
            end
        end
    endtask

    task automatic test_alu;
        for (int i = 0; i < 8; i++) begin
            idle_controls();
            bus.Ins = {3'(i), 3'(i), 3'(i), 2'b00};
            tick();
            {bus.PSW_C, bus.ALUop, bus.Flag} = 3'(i);
            #1;
            checks++;
            if (bus.Sum !== exp_sum[i] || bus.C !== exp_c[i] || bus.Z !== exp_z[i] || bus.N !== exp_n[i]) begin
                failures++;
                $display("FAIL alu[%0d] got Sum=%h NZC=%b%b%b want Sum=%h NZC=%b%b%b", i,
                         bus.Sum, bus.N, bus.Z, bus.C, exp_sum[i], exp_n[i], exp_z[i], exp_c[i]);
            end
        end
    endtask

    task automatic test_wrap_imm;
        idle_controls();
        bus.Ins    = 11'd0;
        bus.WBData = 16'hFFFF;
        bus.WBRF   = 1'b1;
        tick();
        bus.WBRF = 1'b0;
        bus.Ins  = {3'd0, 3'd0, 5'd1};
        tick();
        bus.OprandB = 1'b1;
        #1;
        checks++;
        if (bus.Sum !== 16'h0000 || bus.C !== 1'b1 || bus.Z !== 1'b1 || bus.N !== 1'b0) begin
            failures++;
            $display("FAIL wrap got Sum=%h NZC=%b%b%b want 0000 011", bus.Sum, bus.N, bus.Z, bus.C);
        end
        // imm5 = 31 must be zero-extended: 3 + 31 = 0x22 via RF[2]=3
        bus.OprandB = 1'b0;
        bus.Ins     = {3'd0, 3'd2, 5'd31};
        tick();
        bus.OprandB = 1'b1;
        #1;
        checks++;
        if (bus.Sum !== 16'h0022 || bus.C !== 1'b0) begin
            failures++;
            $display("FAIL imm5_max got Sum=%h C=%b want 0022 0", bus.Sum, bus.C);
        end
    endtask

    task automatic test_li;
        idle_controls();
        bus.Ins        = {3'd1, 8'h55};
        bus.RBresource = 1'b1;
        tick();
        bus.LI = 1'b1;
        #1;
        checks++;
        if (bus.LI_EXE !== 16'h5502) begin
            failures++;
            $display("FAIL lhi got %h want 5502", bus.LI_EXE);
        end
        bus.Ins = {3'd1, 8'h44};
        tick();
        bus.LI = 1'b0;
        #1;
        checks++;
        if (bus.LI_EXE !== 16'h0044) begin
            failures++;
            $display("FAIL lli got %h want 0044", bus.LI_EXE);
        end
    endtask

    task automatic test_ldr;
        idle_controls();
        bus.Ins        = {3'd1, 8'd0};
        bus.WBRF       = 1'b1;
        bus.WBresource = 1'b1;
        bus.MEMData    = 16'h1100;
        bus.WBData     = 16'h0404;
        tick();
        bus.WBRF = 1'b0;
        #1;
        checks++;
        if (bus.Rd !== 16'h1100) begin
            failures++;
            $display("FAIL ldr_rd got %h want 1100", bus.Rd);
        end
        checks++;
`ifdef RF_BYPASS_EN
        if (bus.OutR !== 16'h1100) begin
            failures++;
            $display("FAIL ldr_same_edge got %h want 1100", bus.OutR);
        end
`else
        if (bus.OutR !== 16'h0002) begin
            failures++;
            $display("FAIL ldr_same_edge got %h want 0002", bus.OutR);
        end
`endif
        tick();
        checks++;
        if (bus.OutR !== 16'h1100) begin
            failures++;
            $display("FAIL ldr_outr got %h want 1100", bus.OutR);
        end
    endtask

    task automatic test_reset_mid;
        idle_controls();
        bus.Ins = {3'd1, 3'd1, 5'd0};
        tick();
        #2;
        Reset = 1'b0;
        #1;
        checks++;
        if (bus.Rm !== 16'h0 || bus.Rd !== 16'h0 || bus.OutR !== 16'h0) begin
            failures++;
            $display("FAIL reset_mid got Rm=%h Rd=%h OutR=%h want 0", bus.Rm, bus.Rd, bus.OutR);
        end
        @(negedge clk);
        Reset = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        Reset    = 1'b0;
        test_reset();
        test_rf_fill();
        test_x_no_write();
        test_alu();
        test_wrap_imm();
        test_li();
        test_ldr();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
